load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 encodings, LSU FSM states and a legality helper.
// Pure definitions with no timing or flow-control behaviour of their own.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Unsigned variants only exist for loads; doubleword forms need a 64-bit datapath.
  function automatic logic funct3_ok(input logic [2:0] f3, input logic we, input int xlen);
    case (f3)
      F3_B, F3_H, F3_W: funct3_ok = 1'b1;
      F3_D:             funct3_ok = (xlen == 64);
      F3_BU, F3_HU:     funct3_ok = !we;
      F3_WU:            funct3_ok = !we && (xlen == 64);
      default:          funct3_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: the LSU is master, memory is slave; one beat completes per cycle
// on bus_req & bus_ready, and bus_ready low stretches the beat.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN/8-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ready;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables over two adjacent words, store rotation,
// load extraction and sign/zero extension. Purely combinational, no flow control.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                funct3,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [XLEN-1:0]           st_data,
  input  logic [XLEN-1:0]           rd_lo,
  input  logic [XLEN-1:0]           rd_hi,
  output logic [XLEN/8-1:0]         be_lo,
  output logic [XLEN/8-1:0]         be_hi,
  output logic [XLEN-1:0]           st_lanes,
  output logic [XLEN-1:0]           ld_data,
  output logic                      spans
);
  localparam int NB = XLEN / 8;

  logic [3:0]      nbytes;
  logic [2*NB-1:0] size_mask;
  logic [2*NB-1:0] mask2;
  logic [XLEN-1:0] ld_raw;
  logic            sbit;
  int              sh;

  always_comb begin
    nbytes    = 4'd1 << funct3[1:0];
    size_mask = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      size_mask[i] = (i < int'(nbytes));
    end
    // Lanes past the top of the first word spill into the next aligned word.
    mask2 = size_mask << offset;
    be_lo = mask2[NB-1:0];
    be_hi = mask2[2*NB-1:NB];
    spans = |be_hi;

    sh       = int'({offset, 3'b000});
    st_lanes = (st_data << sh) | (st_data >> (XLEN - sh));
    ld_raw   = XLEN'({rd_hi, rd_lo} >> sh);

    case (funct3[1:0])
      2'd0:    sbit = ld_raw[7];
      2'd1:    sbit = ld_raw[15];
      2'd2:    sbit = ld_raw[31];
      default: sbit = ld_raw[XLEN-1];
    endcase
    sbit = sbit & ~funct3[2];

    ld_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < 8 * int'(nbytes)) ? ld_raw[i] : sbit;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: one request at a time, lsu_done 2 cycles after accept on a zero-wait bus.
// bus_ready stretches beats (bounded by TIMEOUT_CYCLES); LSU_MISALIGN_EN splits word-crossing accesses.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_err,
  load_store_unit_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            in_beat;
  logic            misal_err;
  logic            spans;
  logic [NB-1:0]   be_lo, be_hi;
  logic [XLEN-1:0] st_lanes, ld_data, word_base;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (f3_q),
    .offset   (addr_q[OW-1:0]),
    .st_data  (wdata_q),
    .rd_lo    ((state_q == ST_BEAT1) ? lo_q : bus.bus_rdata),
    .rd_hi    (bus.bus_rdata),
    .be_lo    (be_lo),
    .be_hi    (be_hi),
    .st_lanes (st_lanes),
    .ld_data  (ld_data),
    .spans    (spans)
  );

`ifdef LSU_MISALIGN_EN
  assign misal_err = 1'b0;
`else
  logic [3:0] ex_size_m1;
  assign ex_size_m1 = (4'd1 << ex_funct3[1:0]) - 4'd1;
  assign misal_err  = |(4'(ex_addr[OW-1:0]) & ex_size_m1);
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    tmo_d   = tmo_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          we_d    = ex_we;
          f3_d    = ex_funct3;
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          tmo_d   = '0;
          if (!funct3_ok(ex_funct3, ex_we, XLEN) || misal_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BEAT0;
          end
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus.bus_ready) begin
          tmo_d = '0;
          if (state_q == ST_BEAT0 && spans) begin
            state_d = ST_BEAT1;
            lo_d    = bus.bus_rdata;
          end else begin
            state_d = ST_RESP;
            rdata_d = we_q ? '0 : ld_data;
          end
        end else if (TIMEOUT_CYCLES > 0 && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign in_beat   = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign word_base = {addr_q[XLEN-1:OW], {OW{1'b0}}};

  assign lsu_busy  = ((state_q == ST_IDLE) && ex_valid) || in_beat;
  assign lsu_done  = (state_q == ST_RESP);
  assign lsu_rdata = rdata_q;
  assign lsu_err   = err_q;

  assign bus.bus_req   = in_beat;
  assign bus.bus_we    = in_beat && we_q;
  assign bus.bus_addr  = !in_beat ? '0 :
                         (state_q == ST_BEAT1) ? word_base + XLEN'(NB) : word_base;
  assign bus.bus_be    = (state_q == ST_BEAT0) ? be_lo :
                         (state_q == ST_BEAT1) ? be_hi : '0;
  assign bus.bus_wdata = (in_beat && we_q) ? st_lanes : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-memory reference model, random-wait bus responder and a done-driven scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_we = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;

  load_store_unit_if #(.XLEN(32)) bus_if ();

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .bus(bus_if)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  beat_t       beats[$];
  logic [32:0] exp_q[$];
  logic [7:0]  bmem [0:511];
  logic [7:0]  rmem [0:511];
  int          n_checks = 0, n_pass = 0, cyc = 0;
  int          wmin = 0, wmax = 0;
  bit          hold_off = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Architectural view: a byte-addressed memory and the RISC-V load/store rules.
  task automatic model(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int     size;
    bit     legal, misal;
    longint v;
    size  = 1 << f3[1:0];
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    misal = (addr % size) != 0;
`ifdef LSU_MISALIGN_EN
    misal = 1'b0;
`endif
    rd = '0;
    er = 1'b0;
    v  = 0;
    if (!legal || misal) begin
      er = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) rmem[addr + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) v += longint'(rmem[addr + i]) << (8 * i);
      if (!f3[2] && v[8*size-1]) v -= (longint'(1) << (8 * size));
      rd = v[31:0];
    end
  endtask

  // Bus responder: random wait states, applies completed write beats to its own memory.
  int          wcnt = 0, cur_wait = 0, ra = 0;
  logic        p_req = 1'b0, p_rdy = 1'b0, p_rst = 1'b1, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_be = '0;

  initial begin : responder
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (p_req && p_rdy && !p_rst) begin
        if (p_we)
          for (int i = 0; i < 4; i++)
            if (p_be[i]) bmem[int'((p_addr + 32'(i)) & 32'h1FF)] = p_wdata[8*i +: 8];
        beats.push_back('{p_addr, p_be, p_wdata, p_we});
        wcnt     = 0;
        cur_wait = $urandom_range(wmin, wmax);
      end
      if (!bus_if.bus_req) begin
        wcnt     = 0;
        cur_wait = $urandom_range(wmin, wmax);
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
      end else if (!hold_off && wcnt >= cur_wait) begin
        ra = int'(bus_if.bus_addr & 32'h1FC);
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = {bmem[ra+3], bmem[ra+2], bmem[ra+1], bmem[ra]};
      end else begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
        wcnt++;
      end
      #1;
      p_req   = bus_if.bus_req;
      p_rdy   = bus_if.bus_ready;
      p_rst   = rst;
      p_we    = bus_if.bus_we;
      p_addr  = bus_if.bus_addr;
      p_be    = bus_if.bus_be;
      p_wdata = bus_if.bus_wdata;
    end
  end

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (lsu_done) begin
        if (exp_q.size() == 0) begin
          check("done_without_request", {63'b0, lsu_done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("response_err_rdata", {31'b0, lsu_err, lsu_rdata}, {31'b0, e});
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input int wlo, input int whi, input bit stall, output int lat, output int nreq);
    logic [31:0] er;
    logic        ee;
    int          c0;
    model(we, f3, int'(addr), wd, er, ee);
    if (stall) begin
      er = '0;
      ee = 1'b1;
    end
    wmin = wlo;
    wmax = whi;
    hold_off = stall;
    @(negedge clk);
    exp_q.push_back({ee, er});
    ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
    c0   = cyc;
    lat  = -1;
    nreq = 0;
    @(negedge clk);
    ex_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.bus_req) nreq++;
      if (lsu_done) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL done_wait: no lsu_done within 100 cycles, required one");
    end
    @(negedge clk);
  endtask

  logic [2:0] f3_tab [10];

  initial begin : main
    int         lat, nreq, nmis, ndone;
    logic [2:0] f3;
    logic       we_r;
    for (int i = 0; i < 512; i++) begin
      bmem[i] = 8'($urandom);
      rmem[i] = bmem[i];
    end
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, lsu_busy}, 64'd0);
    check("rst_done", {63'b0, lsu_done}, 64'd0);
    check("rst_err", {63'b0, lsu_err}, 64'd0);
    check("rst_rdata", {32'b0, lsu_rdata}, 64'd0);
    check("rst_bus_req", {63'b0, bus_if.bus_req}, 64'd0);
    check("rst_bus_we", {63'b0, bus_if.bus_we}, 64'd0);
    check("rst_bus_addr", {32'b0, bus_if.bus_addr}, 64'd0);
    check("rst_bus_be", {60'b0, bus_if.bus_be}, 64'd0);
    check("rst_bus_wdata", {32'b0, bus_if.bus_wdata}, 64'd0);
    rst = 1'b0;

    beats.delete();
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0, lat, nreq);
    check("sw_beats", 64'(beats.size()), 64'd1);
    check("sw_addr", {32'b0, beats[0].addr}, 64'h100);
    check("sw_be", {60'b0, beats[0].be}, 64'hF);
    check("sw_wdata", {32'b0, beats[0].wdata}, 64'hDEADBEEF);
    check("sw_latency", 64'(lat), 64'd2);

    {bmem[256], bmem[257], bmem[258], bmem[259]} = {8'h00, 8'h00, 8'hFF, 8'h80};
    {rmem[256], rmem[257], rmem[258], rmem[259]} = {8'h00, 8'h00, 8'hFF, 8'h80};
    issue(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0, lat, nreq);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 1'b0, lat, nreq);

    beats.delete();
    issue(1'b1, 3'b001, 32'h102, 32'h00001234, 3, 3, 1'b0, lat, nreq);
    check("sh_be", {60'b0, beats[0].be}, 64'hC);
    check("sh_wdata_hi", {48'b0, beats[0].wdata[31:16]}, 64'h1234);
    check("sh_latency", 64'(lat), 64'd5);

    {bmem[258], bmem[259], bmem[260], bmem[261]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {rmem[258], rmem[259], rmem[260], rmem[261]} = {8'h11, 8'h22, 8'h33, 8'h44};
    beats.delete();
    issue(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 1'b0, lat, nreq);
`ifdef LSU_MISALIGN_EN
    check("split_beats", 64'(beats.size()), 64'd2);
    check("split_b0_addr", {32'b0, beats[0].addr}, 64'h100);
    check("split_b0_be", {60'b0, beats[0].be}, 64'hC);
    check("split_b1_addr", {32'b0, beats[1].addr}, 64'h104);
    check("split_b1_be", {60'b0, beats[1].be}, 64'h3);
`else
    check("misal_no_bus_req", 64'(nreq), 64'd0);
    check("misal_latency", 64'(lat), 64'd1);
`endif

    beats.delete();
    issue(1'b0, 3'b010, 32'h108, 32'h0, 0, 0, 1'b1, lat, nreq);
    check("timeout_req_cycles", 64'(nreq), 64'd16);
    check("timeout_latency", 64'(lat), 64'd17);
    check("timeout_no_beat", 64'(beats.size()), 64'd0);
    check("timeout_req_dropped", {63'b0, bus_if.bus_req}, 64'd0);

    @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h10C;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rst_abort_in_beat", {63'b0, bus_if.bus_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_bus_req", {63'b0, bus_if.bus_req}, 64'd0);
    check("rst_abort_busy", {63'b0, lsu_busy}, 64'd0);
    check("rst_abort_done", {63'b0, lsu_done}, 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (lsu_done) ndone++;
    end
    check("rst_abort_no_done", 64'(ndone), 64'd0);
    hold_off = 1'b0;

    for (int n = 0; n < 300; n++) begin
      f3   = f3_tab[$urandom_range(0, 9)];
      we_r = 1'($urandom_range(0, 1));
      if (we_r && (f3 == 3'd4 || f3 == 3'd5)) f3[2] = 1'b0;
      issue(we_r, f3, 32'($urandom_range(0, 'h1F0)), $urandom, 0, 3, 1'b0, lat, nreq);
    end

    nmis = 0;
    for (int i = 0; i < 512; i++) if (bmem[i] !== rmem[i]) nmis++;
    check("memory_image", 64'(nmis), 64'd0);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
